// File: rtl/jump_pkg.sv
// jump_pkg: shared defaults and redirect record for the jump redirect path
//   JUMP_ADDR_W / JUMP_DEPTH : default target width and buffer depth
//   redirect_t               : {branch, addr} record at the default width
package jump_pkg;
   localparam int JUMP_ADDR_W = 32;
   localparam int JUMP_DEPTH  = 4;
   typedef struct packed {
      logic                   branch;
      logic [JUMP_ADDR_W-1:0] addr;
   } redirect_t;
endpackage

// File: rtl/jump_redirect_fifo.sv
// jump_redirect_fifo: in-order buffer of branch redirects with occupancy high-water mark
//   clk, rsta                           : clock, async active-low reset
//   in_valid/in_ready/in_branch/in_addr : producer side
//   out_valid/out_ready/out_branch/out_addr : consumer side, zeroed while empty
//   flush                               : sync discard of all entries and hwm
//   count, hwm                          : occupancy and peak occupancy
module jump_redirect_fifo
   import jump_pkg::*;
#(
   parameter int ADDR_W  = JUMP_ADDR_W,
   parameter int DEPTH   = JUMP_DEPTH,
   parameter int DROP_NT = 1
) (
   input  logic                     clk,
   input  logic                     rsta,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_branch,
   input  logic [ADDR_W-1:0]        in_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_branch,
   output logic [ADDR_W-1:0]        out_addr,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   hwm
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_W:0]   mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count_next;
   logic              push, pop;
   assign in_ready  = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign {out_branch, out_addr} = out_valid ? mem[rd_ptr] : '0;
   // not-taken beats are accepted on the handshake but never stored
   assign push = in_valid && in_ready && (in_branch || DROP_NT == 0);
   assign pop  = out_valid && out_ready;
   assign count_next = (push && !pop) ? count + CW'(1) :
                       (pop && !push) ? count - CW'(1) : count;
   always_ff @(posedge clk)
      if (push && !flush) mem[wr_ptr] <= {in_branch, in_addr};
   always_ff @(posedge clk or negedge rsta)
      if (!rsta) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         hwm    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         hwm    <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
         count  <= count_next;
         hwm    <= (count_next > hwm) ? count_next : hwm;
      end
endmodule

// File: tb/tb_jump_redirect_fifo.sv
// tb_jump_redirect_fifo: randomized and directed scoreboard bench for jump_redirect_fifo
module tb_jump_redirect_fifo;
   import jump_pkg::*;
   localparam int DEPTH = 4;
   logic        clk = 0, rsta = 0;
   logic        in_valid = 0, in_branch = 0, out_ready = 0, flush = 0;
   logic [31:0] in_addr = 0;
   logic        in_ready, out_valid, out_branch;
   logic [31:0] out_addr;
   logic [2:0]  count, hwm;
   int          checks = 0, errors = 0;
   redirect_t   exp_q[$];
   int          hwm_m = 0;
   bit          do_pop, do_push;

   jump_redirect_fifo dut (
      .clk(clk), .rsta(rsta), .in_valid(in_valid), .in_ready(in_ready),
      .in_branch(in_branch), .in_addr(in_addr), .out_valid(out_valid),
      .out_ready(out_ready), .out_branch(out_branch), .out_addr(out_addr),
      .flush(flush), .count(count), .hwm(hwm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge; the monitor below samples on the falling edge
   task automatic step(input logic v, input logic b, input logic [31:0] a,
                       input logic r, input logic f);
      in_valid = v; in_branch = b; in_addr = a; out_ready = r; flush = f;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
   endtask

   // reference model: exp_q holds the entries the buffer should contain, head first
   always @(negedge clk) begin
      if (!rsta) begin
         exp_q.delete();
         hwm_m = 0;
         chk("rst_count", count, 0);
         chk("rst_hwm", hwm, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_addr", {out_branch, out_addr}, 0);
         chk("rst_in_ready", in_ready, 1);
      end else begin
         chk("count", count, exp_q.size());
         chk("hwm", hwm, hwm_m);
         chk("in_ready", in_ready, exp_q.size() != DEPTH);
         chk("out_valid", out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("out_addr", out_addr, exp_q[0].addr);
            chk("out_branch", out_branch, exp_q[0].branch);
         end else
            chk("empty_out_zero", {out_branch, out_addr}, 0);
         if (flush) begin
            exp_q.delete();
            hwm_m = 0;
         end else begin
            do_pop  = out_ready && exp_q.size() > 0;
            do_push = in_valid && exp_q.size() < DEPTH && in_branch;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{branch: 1'b1, addr: in_addr});
            if (exp_q.size() > hwm_m) hwm_m = exp_q.size();
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rsta = 1;
      // single push visible next cycle
      step(1, 1, 32'h40, 0, 0);
      idle(1);
      drain(2);
      // fill, overflow attempt, ordered drain
      step(1, 1, 32'h10, 0, 0);
      step(1, 1, 32'h20, 0, 0);
      step(1, 1, 32'h30, 0, 0);
      step(1, 1, 32'h40, 0, 0);
      step(1, 1, 32'h50, 0, 0);
      drain(5);
      // push+pop at full, then at count 3
      for (int i = 0; i < 4; i++) step(1, 1, 32'h200 + i, 0, 0);
      step(1, 1, 32'h99, 1, 0);
      step(1, 1, 32'hAA, 1, 0);
      drain(5);
      // not-taken beat dropped
      step(1, 0, 32'h80, 0, 0);
      idle(2);
      // flush beats a simultaneous push
      for (int i = 0; i < 3; i++) step(1, 1, 32'h300 + i, 0, 0);
      step(1, 1, 32'h77, 0, 1);
      idle(2);
      // asynchronous reset between edges with two entries held
      step(1, 1, 32'h400, 0, 0);
      step(1, 1, 32'h401, 0, 0);
      in_valid = 0;
      #2 rsta = 0;
      #1;
      chk("async_count", count, 0);
      chk("async_out_valid", out_valid, 0);
      chk("async_out_addr", out_addr, 0);
      chk("async_in_ready", in_ready, 1);
      @(posedge clk); #1 rsta = 1;
      step(1, 1, 32'h100, 0, 0);
      idle(2);
      drain(2);
      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom,
              $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
      drain(6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
